// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the accumulator-machine control unit.
// Holds the bus select codes, AC/E operation codes, opcode values and IR bit indices.
package ctrl_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_t;

  typedef enum logic [3:0] {
    AC_NOP, AC_AND, AC_ADD, AC_LDDR, AC_CLR, AC_CMA, AC_SHR, AC_SHL, AC_INC, AC_INPR
  } ac_op_t;

  typedef enum logic [1:0] {
    E_NOP, E_CLR, E_CMP, E_ALU
  } e_op_t;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_LDA    = 3'd2;
  localparam logic [2:0] OP_STA    = 3'd3;
  localparam logic [2:0] OP_BUN    = 3'd4;
  localparam logic [2:0] OP_BSA    = 3'd5;
  localparam logic [2:0] OP_ISZ    = 3'd6;
  localparam logic [2:0] OP_REGREF = 3'd7;

  localparam int unsigned IR_I     = 15;
  localparam int unsigned IR_OP_HI = 14;
  localparam int unsigned IR_OP_LO = 12;

  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  localparam int unsigned IO_INP = 11;
  localparam int unsigned IO_OUT = 10;
  localparam int unsigned IO_SKI = 9;
  localparam int unsigned IO_SKO = 8;
  localparam int unsigned IO_ION = 7;
  localparam int unsigned IO_IOF = 6;

endpackage

// File: rtl/ctrl_sequencer_sc_counter.sv
// sc_counter: W-bit sequence counter, async active-high reset, clear has priority over increment.
// Ports: clk, rst, inr (increment), clr (clear), cnt (current count).
module sc_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inr,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inr) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: timing/control unit of the 16-bit accumulator machine.
// Inputs: CLK, RST (async, active-high), IR, FGI, FGO.
// Outputs: busSEL, memRD/memWR, register strobes, skip strobes, acOP, eOP,
//          fgiCLR/fgoCLR, S (running) and T (sequence counter).
// Optional: INTERRUPT_EN adds the IEN and R flip-flops and the interrupt cycle.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SC_W = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   IR,
  input  logic            FGI,
  input  logic            FGO,
  output logic [2:0]      busSEL,
  output logic            memRD,
  output logic            memWR,
  output logic            arLD,
  output logic            arINR,
  output logic            arCLR,
  output logic            pcLD,
  output logic            pcINR,
  output logic            pcCLR,
  output logic            irLD,
  output logic            drLD,
  output logic            drINR,
  output logic            trLD,
  output logic            outLD,
  output logic            ISZ,
  output logic            SPA,
  output logic            SNA,
  output logic            SZA,
  output logic            SZE,
  output ac_op_t          acOP,
  output e_op_t           eOP,
  output logic            fgiCLR,
  output logic            fgoCLR,
  output logic            S,
  output logic [SC_W-1:0] T
);

  logic [2:0]      d_q, d_d;
  logic            i_q, i_d;
  logic            s_q, s_d;
  logic            sc_clr;
  logic [SC_W-1:0] sc_t;
  bus_sel_t        bus_sel;

  sc_counter #(.W(SC_W)) u_sc (
    .clk (CLK),
    .rst (RST),
    .inr (s_q),
    .clr (sc_clr),
    .cnt (sc_t)
  );

`ifdef INTERRUPT_EN
  logic ien_q, ien_d;
  logic r_q, r_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ien_q <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      ien_q <= ien_d;
      r_q   <= r_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_q <= '0;
      i_q <= 1'b0;
      s_q <= 1'b1;
    end else begin
      d_q <= d_d;
      i_q <= i_d;
      s_q <= s_d;
    end
  end

  always_comb begin
    d_d     = d_q;
    i_d     = i_q;
    s_d     = s_q;
`ifdef INTERRUPT_EN
    ien_d   = ien_q;
    r_d     = r_q;
`endif
    sc_clr  = 1'b0;
    bus_sel = BUS_NONE;
    memRD   = 1'b0;
    memWR   = 1'b0;
    arLD    = 1'b0;
    arINR   = 1'b0;
    arCLR   = 1'b0;
    pcLD    = 1'b0;
    pcINR   = 1'b0;
    pcCLR   = 1'b0;
    irLD    = 1'b0;
    drLD    = 1'b0;
    drINR   = 1'b0;
    trLD    = 1'b0;
    outLD   = 1'b0;
    ISZ     = 1'b0;
    SPA     = 1'b0;
    SNA     = 1'b0;
    SZA     = 1'b0;
    SZE     = 1'b0;
    acOP    = AC_NOP;
    eOP     = E_NOP;
    fgiCLR  = 1'b0;
    fgoCLR  = 1'b0;

    if (!s_q) begin
      sc_clr = 1'b1;
    end else if (sc_t > SC_W'(6)) begin
      sc_clr = 1'b1;
`ifdef INTERRUPT_EN
    end else if (!r_q && (sc_t <= SC_W'(2)) && ien_q && (FGI || FGO)) begin
      // Entry cycle issues no strobes and restarts T, so the R cycle always begins at T0.
      r_d    = 1'b1;
      sc_clr = 1'b1;
    end else if (r_q) begin
      case (sc_t)
        SC_W'(0): begin arCLR = 1'b1; trLD = 1'b1; bus_sel = BUS_PC; end
        SC_W'(1): begin memWR = 1'b1; bus_sel = BUS_TR; pcCLR = 1'b1; end
        SC_W'(2): begin pcINR = 1'b1; ien_d = 1'b0; r_d = 1'b0; sc_clr = 1'b1; end
        default:  sc_clr = 1'b1;
      endcase
`endif
    end else begin
      case (sc_t)
        SC_W'(0): begin arLD = 1'b1; bus_sel = BUS_PC; end
        SC_W'(1): begin irLD = 1'b1; memRD = 1'b1; bus_sel = BUS_MEM; pcINR = 1'b1; end
        SC_W'(2): begin
          arLD    = 1'b1;
          bus_sel = BUS_IR;
          d_d     = IR[IR_OP_HI:IR_OP_LO];
          i_d     = IR[IR_I];
        end
        SC_W'(3): begin
          if (d_q == OP_REGREF) begin
            sc_clr = 1'b1;
            if (i_q) begin
              if      (IR[IO_INP]) begin acOP = AC_INPR; fgiCLR = 1'b1; end
              else if (IR[IO_OUT]) begin outLD = 1'b1; bus_sel = BUS_AC; fgoCLR = 1'b1; end
              else if (IR[IO_SKI]) pcINR = FGI;
              else if (IR[IO_SKO]) pcINR = FGO;
`ifdef INTERRUPT_EN
              else if (IR[IO_ION]) ien_d = 1'b1;
              else if (IR[IO_IOF]) ien_d = 1'b0;
`endif
            end else begin
              if      (IR[RR_CLA]) acOP = AC_CLR;
              else if (IR[RR_CLE]) eOP = E_CLR;
              else if (IR[RR_CMA]) acOP = AC_CMA;
              else if (IR[RR_CME]) eOP = E_CMP;
              else if (IR[RR_CIR]) begin acOP = AC_SHR; eOP = E_ALU; end
              else if (IR[RR_CIL]) begin acOP = AC_SHL; eOP = E_ALU; end
              else if (IR[RR_INC]) acOP = AC_INC;
              else if (IR[RR_SPA]) SPA = 1'b1;
              else if (IR[RR_SNA]) SNA = 1'b1;
              else if (IR[RR_SZA]) SZA = 1'b1;
              else if (IR[RR_SZE]) SZE = 1'b1;
              else if (IR[RR_HLT]) s_d = 1'b0;
            end
          end else if (i_q) begin
            arLD = 1'b1; memRD = 1'b1; bus_sel = BUS_MEM;
          end
        end
        default: begin
          case (d_q)
            OP_AND, OP_ADD, OP_LDA: begin
              if (sc_t == SC_W'(4)) begin
                drLD = 1'b1; memRD = 1'b1; bus_sel = BUS_MEM;
              end else begin
                sc_clr = 1'b1;
                if (sc_t == SC_W'(5)) begin
                  if (d_q == OP_AND)      begin acOP = AC_AND; eOP = E_NOP; end
                  else if (d_q == OP_ADD) begin acOP = AC_ADD; eOP = E_ALU; end
                  else                    acOP = AC_LDDR;
                end
              end
            end
            OP_STA: begin
              sc_clr = 1'b1;
              if (sc_t == SC_W'(4)) begin memWR = 1'b1; bus_sel = BUS_AC; end
            end
            OP_BUN: begin
              sc_clr = 1'b1;
              if (sc_t == SC_W'(4)) begin pcLD = 1'b1; bus_sel = BUS_AR; end
            end
            OP_BSA: begin
              if (sc_t == SC_W'(4)) begin
                memWR = 1'b1; bus_sel = BUS_PC; arINR = 1'b1;
              end else begin
                sc_clr = 1'b1;
                if (sc_t == SC_W'(5)) begin pcLD = 1'b1; bus_sel = BUS_AR; end
              end
            end
            OP_ISZ: begin
              if (sc_t == SC_W'(4)) begin
                drLD = 1'b1; memRD = 1'b1; bus_sel = BUS_MEM;
              end else if (sc_t == SC_W'(5)) begin
                drINR = 1'b1;
              end else begin
                memWR = 1'b1; bus_sel = BUS_DR; ISZ = 1'b1; sc_clr = 1'b1;
              end
            end
            default: sc_clr = 1'b1;
          endcase
        end
      endcase
    end
  end

  assign busSEL = bus_sel;
  assign S      = s_q;
  assign T      = sc_t;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IR;
  logic        FGI, FGO;
  logic [2:0]  busSEL;
  logic        memRD, memWR, arLD, arINR, arCLR, pcLD, pcINR, pcCLR, irLD;
  logic        drLD, drINR, trLD, outLD, ISZ, SPA, SNA, SZA, SZE;
  ac_op_t      acOP;
  e_op_t       eOP;
  logic        fgiCLR, fgoCLR, S;
  logic [2:0]  T;

  ctrl_sequencer #(.DW(16), .SC_W(3)) dut (
    .CLK(CLK), .RST(RST), .IR(IR), .FGI(FGI), .FGO(FGO),
    .busSEL(busSEL), .memRD(memRD), .memWR(memWR),
    .arLD(arLD), .arINR(arINR), .arCLR(arCLR),
    .pcLD(pcLD), .pcINR(pcINR), .pcCLR(pcCLR), .irLD(irLD),
    .drLD(drLD), .drINR(drINR), .trLD(trLD), .outLD(outLD),
    .ISZ(ISZ), .SPA(SPA), .SNA(SNA), .SZA(SZA), .SZE(SZE),
    .acOP(acOP), .eOP(eOP), .fgiCLR(fgiCLR), .fgoCLR(fgoCLR),
    .S(S), .T(T)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] bus;
    logic mem_rd, mem_wr, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, ir_ld;
    logic dr_ld, dr_inr, tr_ld, out_ld, isz, spa, sna, sza, sze;
    logic [3:0] acop;
    logic [1:0] eop;
    logic fgi_clr, fgo_clr, s;
    logic [2:0] t;
  } snap_t;

  snap_t obs;
  assign obs = {busSEL, memRD, memWR, arLD, arINR, arCLR, pcLD, pcINR, pcCLR, irLD,
                drLD, drINR, trLD, outLD, ISZ, SPA, SNA, SZA, SZE,
                acOP, eOP, fgiCLR, fgoCLR, S, T};

  snap_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  watch_wr = 1'b0;
  logic  wr_seen  = 1'b0;

  always @(posedge memWR) if (watch_wr) wr_seen = 1'b1;

  function automatic snap_t base(input logic [2:0] t);
    snap_t e;
    e   = '0;
    e.s = 1'b1;
    e.t = t;
    return e;
  endfunction

  function automatic snap_t fetch(input int k);
    snap_t e;
    e = base(3'(k));
    if (k == 0) begin e.ar_ld = 1; e.bus = 3'd2; end
    else if (k == 1) begin e.ir_ld = 1; e.mem_rd = 1; e.bus = 3'd7; e.pc_inr = 1; end
    else begin e.ar_ld = 1; e.bus = 3'd5; end
    return e;
  endfunction

  task automatic push_fetch();
    for (int k = 0; k < 3; k++) exp_q.push_back(fetch(k));
  endtask

  task automatic test_reset();
    snap_t e, r;
    RST = 1'b1; IR = 16'h0000; FGI = 1'b0; FGO = 1'b0;
    #1;
    r = fetch(0);
    n_cmp++;
    if (obs !== r) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, r); end
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (obs !== r) begin n_bad++; $display("FAIL reset_held: got %h want %h", obs, r); end
    RST = 1'b0;
  endtask

  task automatic test_reset_abort();
    snap_t e, r;
    IR = 16'h6010; wr_seen = 1'b0; watch_wr = 1'b1;
    push_fetch();
    exp_q.push_back(base(3'd3));
    e = base(3'd4); e.dr_ld = 1; e.mem_rd = 1; e.bus = 3'd7; exp_q.push_back(e);
    repeat (5) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL abort_seq t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
    #1; e = base(3'd5); e.dr_inr = 1; n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_t5: got %h want %h", obs, e); end
    RST = 1'b1;
    #1; r = fetch(0); n_cmp++;
    if (obs !== r) begin n_bad++; $display("FAIL abort_reset: got %h want %h", obs, r); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    watch_wr = 1'b0;
    n_cmp++;
    if (wr_seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_write: got %b want 0", wr_seen); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_add_direct();
    snap_t e;
    IR = 16'h1123;
    push_fetch();
    exp_q.push_back(base(3'd3));
    e = base(3'd4); e.dr_ld = 1; e.mem_rd = 1; e.bus = 3'd7; exp_q.push_back(e);
    e = base(3'd5); e.acop = AC_ADD; e.eop = E_ALU; exp_q.push_back(e);
    repeat (6) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL add_direct t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
    #1; n_cmp++;
    if (T !== 3'd0 || arLD !== 1'b1) begin n_bad++; $display("FAIL add_wrap: got T=%0d arLD=%b want T=0 arLD=1", T, arLD); end
  endtask

  task automatic test_lda_indirect();
    snap_t e;
    IR = 16'hA050;
    push_fetch();
    e = base(3'd3); e.ar_ld = 1; e.mem_rd = 1; e.bus = 3'd7; exp_q.push_back(e);
    e = base(3'd4); e.dr_ld = 1; e.mem_rd = 1; e.bus = 3'd7; exp_q.push_back(e);
    e = base(3'd5); e.acop = AC_LDDR; exp_q.push_back(e);
    repeat (6) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL lda_indirect t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    snap_t e;
    // STA then BUN then BSA, each starting immediately after the previous clears T.
    IR = 16'h3005;
    push_fetch();
    exp_q.push_back(base(3'd3));
    e = base(3'd4); e.mem_wr = 1; e.bus = 3'd4; exp_q.push_back(e);
    repeat (5) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL sta t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
    IR = 16'h4006;
    push_fetch();
    exp_q.push_back(base(3'd3));
    e = base(3'd4); e.pc_ld = 1; e.bus = 3'd1; exp_q.push_back(e);
    repeat (5) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL bun t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
    IR = 16'h5007;
    push_fetch();
    exp_q.push_back(base(3'd3));
    e = base(3'd4); e.mem_wr = 1; e.bus = 3'd2; e.ar_inr = 1; exp_q.push_back(e);
    e = base(3'd5); e.pc_ld = 1; e.bus = 3'd1; exp_q.push_back(e);
    repeat (6) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL bsa t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
  endtask

  task automatic test_isz();
    snap_t e;
    IR = 16'h6010;
    push_fetch();
    exp_q.push_back(base(3'd3));
    e = base(3'd4); e.dr_ld = 1; e.mem_rd = 1; e.bus = 3'd7; exp_q.push_back(e);
    e = base(3'd5); e.dr_inr = 1; exp_q.push_back(e);
    e = base(3'd6); e.mem_wr = 1; e.bus = 3'd3; e.isz = 1; exp_q.push_back(e);
    repeat (7) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL isz t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
  endtask

  task automatic test_regref_io();
    snap_t e;
    logic [15:0] irs [6];
    logic        fgis [6];
    snap_t       t3s [6];
    irs[0] = 16'h7010; t3s[0] = base(3'd3); t3s[0].spa = 1;                        fgis[0] = 0;
    irs[1] = 16'h7A00; t3s[1] = base(3'd3); t3s[1].acop = AC_CLR;                  fgis[1] = 0;
    irs[2] = 16'h7080; t3s[2] = base(3'd3); t3s[2].acop = AC_SHR; t3s[2].eop = E_ALU; fgis[2] = 0;
    irs[3] = 16'hF800; t3s[3] = base(3'd3); t3s[3].acop = AC_INPR; t3s[3].fgi_clr = 1; fgis[3] = 0;
    irs[4] = 16'hF200; t3s[4] = base(3'd3); t3s[4].pc_inr = 1;                     fgis[4] = 1;
    irs[5] = 16'hF200; t3s[5] = base(3'd3);                                        fgis[5] = 0;
    for (int n = 0; n < 6; n++) begin
      IR = irs[n];
      push_fetch();
      exp_q.push_back(t3s[n]);
      for (int c = 0; c < 4; c++) begin
        if (c == 3) FGI = fgis[n];
        #1; e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL regref_io ir=%h t=%0d: got %h want %h", irs[n], e.t, obs, e); end
        @(negedge CLK);
      end
      FGI = 1'b0;
    end
    IR = 16'hF400;
    push_fetch();
    e = base(3'd3); e.out_ld = 1; e.bus = 3'd4; e.fgo_clr = 1; exp_q.push_back(e);
    repeat (4) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL out t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
  endtask

  task automatic test_halt();
    snap_t e, r;
    IR = 16'h7001;
    push_fetch();
    exp_q.push_back(base(3'd3));
    repeat (10) begin e = '0; exp_q.push_back(e); end
    repeat (14) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL halt t=%0d s=%b: got %h want %h", e.t, e.s, obs, e); end
      @(negedge CLK);
    end
    RST = 1'b1;
    #1; r = fetch(0); n_cmp++;
    if (obs !== r) begin n_bad++; $display("FAIL halt_recover: got %h want %h", obs, r); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_interrupt();
    snap_t e;
    IR = 16'hF080;
    push_fetch();
    exp_q.push_back(base(3'd3));
    repeat (4) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL ion t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
    FGI = 1'b1;
`ifdef INTERRUPT_EN
    exp_q.push_back(base(3'd0));
    e = base(3'd0); e.ar_clr = 1; e.tr_ld = 1; e.bus = 3'd2; exp_q.push_back(e);
    e = base(3'd1); e.mem_wr = 1; e.bus = 3'd6; e.pc_clr = 1; exp_q.push_back(e);
    e = base(3'd2); e.pc_inr = 1; exp_q.push_back(e);
    exp_q.push_back(fetch(0));
    exp_q.push_back(fetch(1));
`else
    push_fetch();
    exp_q.push_back(base(3'd3));
    exp_q.push_back(fetch(0));
    exp_q.push_back(fetch(1));
`endif
    repeat (6) begin
      #1; e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL interrupt t=%0d: got %h want %h", e.t, obs, e); end
      @(negedge CLK);
    end
    FGI = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_abort();
    test_add_direct();
    test_lda_indirect();
    test_back_to_back();
    test_isz();
    test_regref_io();
    test_halt();
    test_interrupt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
